// File: rtl/predicate_update_tracker_pkg.sv
// Shared TIA control constants and the in-flight destination record used by the
// predicate update tracker.
package predicate_update_tracker_pkg;

  localparam int TIA_DT_WIDTH       = 2;
  localparam int TIA_DI_WIDTH       = 4;
  localparam int TIA_NUM_PREDICATES = 8;

  localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_PREDICATE = 2'd2;

  typedef struct packed {
    logic                    valid;
    logic                    is_pred;
    logic [TIA_DI_WIDTH-1:0] di;
  } tia_inflight_dest_t;

endpackage

// File: rtl/predicate_update_tracker_if.sv
// Issue/writeback bus and exported predicate state of the predicate update tracker.
interface predicate_update_tracker_if
  import predicate_update_tracker_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int NUM_PREDICATES = TIA_NUM_PREDICATES
) ();

  logic                               stall;
  logic                               flush;
  logic                               issue_valid;
  logic [TIA_DT_WIDTH-1:0]            issue_dt;
  logic [TIA_DI_WIDTH-1:0]            issue_di;
  logic [NUM_PREDICATES-1:0]          issue_up_true_mask;
  logic [NUM_PREDICATES-1:0]          issue_up_false_mask;
  logic                               wb_valid;
  logic                               wb_value;
  logic [NUM_PREDICATES-1:0]          predicates;
  logic [NUM_PREDICATES-1:0]          pending_mask;
  logic                               hazard;
  logic [$clog2(NUM_STAGES+1)-1:0]    pending_count;
  logic                               protocol_error;

  modport master (
    output stall, flush, issue_valid, issue_dt, issue_di,
           issue_up_true_mask, issue_up_false_mask, wb_valid, wb_value,
    input  predicates, pending_mask, hazard, pending_count, protocol_error
  );

  modport slave (
    input  stall, flush, issue_valid, issue_dt, issue_di,
           issue_up_true_mask, issue_up_false_mask, wb_valid, wb_value,
    output predicates, pending_mask, hazard, pending_count, protocol_error
  );

endinterface

// File: rtl/predicate_update_tracker_inflight_destination_shift_register.sv
// Tracks the destination of each issued instruction from issue down to writeback;
// entry 0 is the youngest, the last entry is the one that retires.
module predicate_update_tracker_inflight_destination_shift_register
  import predicate_update_tracker_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                stall,
  input  logic                                flush,
  input  tia_inflight_dest_t                  load,
  output tia_inflight_dest_t [NUM_STAGES-1:0] entries,
  output logic                                retire
);

  // The retiring entry shifts out on the same edge, so flush clearing everything
  // never loses its writeback; retire stays asserted for the top to commit.
  assign retire = !stall && entries[NUM_STAGES-1].valid && entries[NUM_STAGES-1].is_pred;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      entries <= '0;
    end else if (!stall) begin
      entries[0] <= load;
      for (int i = 1; i < NUM_STAGES; i++) begin
        entries[i] <= entries[i-1];
      end
    end
  end

endmodule

// File: rtl/predicate_update_tracker.sv
// Owns the architectural predicate register, applies issue-time updates, retires
// predicate writebacks and exports the pending-predicate hazard state.
module predicate_update_tracker
  import predicate_update_tracker_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int NUM_PREDICATES = TIA_NUM_PREDICATES
) (
  input logic                        clock,
  input logic                        reset,
  predicate_update_tracker_if.slave  bus
);

  localparam int CW = $clog2(NUM_STAGES + 1);

  // An index beyond the register yields an all-zero mask.
  function automatic logic [NUM_PREDICATES-1:0] onehot(input logic [TIA_DI_WIDTH-1:0] di);
    logic [NUM_PREDICATES-1:0] m;
    for (int i = 0; i < NUM_PREDICATES; i++) begin
      m[i] = (int'(di) == i);
    end
    return m;
  endfunction

  tia_inflight_dest_t                  load;
  tia_inflight_dest_t [NUM_STAGES-1:0] entries;
  logic                                retire;
  logic                                accept;
  logic                                issue_is_pred;
  logic [NUM_PREDICATES-1:0]           issue_onehot;
  logic [NUM_PREDICATES-1:0]           retire_onehot;
  logic [NUM_PREDICATES-1:0]           pending;
  logic [CW-1:0]                       count;
  logic [NUM_PREDICATES-1:0]           pred_q;
  logic [NUM_PREDICATES-1:0]           pred_d;
  logic                                err_q;
  logic                                err_set;

  assign accept        = bus.issue_valid && !bus.stall;
  assign issue_is_pred = (bus.issue_dt == TIA_DESTINATION_TYPE_PREDICATE);
  assign issue_onehot  = onehot(bus.issue_di);
  assign retire_onehot = onehot(entries[NUM_STAGES-1].di);

  always_comb begin
    load         = '0;
    load.valid   = accept;
    load.is_pred = issue_is_pred;
    load.di      = bus.issue_di;
  end

  predicate_update_tracker_inflight_destination_shift_register #(
    .NUM_STAGES (NUM_STAGES)
  ) u_inflight (
    .clock   (clock),
    .reset   (reset),
    .stall   (bus.stall),
    .flush   (bus.flush),
    .load    (load),
    .entries (entries),
    .retire  (retire)
  );

  always_comb begin
    pending = '0;
    count   = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (entries[i].valid && entries[i].is_pred) begin
        pending = pending | onehot(entries[i].di);
        count   = count + CW'(1);
      end
    end
  end

  // Issue update is applied after the writeback so the younger instruction wins.
  always_comb begin
    pred_d = pred_q;
    if (retire && bus.wb_valid) begin
      pred_d = (pred_d & ~retire_onehot) | (retire_onehot & {NUM_PREDICATES{bus.wb_value}});
    end
    if (accept && !bus.flush) begin
      pred_d = (pred_d | bus.issue_up_true_mask) & ~bus.issue_up_false_mask;
    end
  end

  always_comb begin
    err_set = (bus.wb_valid != retire);
    if (accept) begin
      if (|(bus.issue_up_true_mask & bus.issue_up_false_mask)) err_set = 1'b1;
      if (issue_is_pred && (issue_onehot == '0))               err_set = 1'b1;
      if (issue_is_pred && |(issue_onehot & pending))          err_set = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pred_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pred_q <= pred_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.predicates     = pred_q;
  assign bus.pending_mask   = pending;
  assign bus.hazard         = |pending;
  assign bus.pending_count  = count;
  assign bus.protocol_error = err_q;

endmodule

// File: tb/tb_predicate_update_tracker.sv
// Directed bench for predicate_update_tracker with NUM_STAGES=2, NUM_PREDICATES=8.
module tb_predicate_update_tracker;
  import predicate_update_tracker_pkg::*;

  localparam logic [1:0] DT_PRED  = TIA_DESTINATION_TYPE_PREDICATE;
  localparam logic [1:0] DT_OTHER = 2'd0;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  predicate_update_tracker_if #(.NUM_STAGES(2), .NUM_PREDICATES(8)) bus ();

  predicate_update_tracker #(.NUM_STAGES(2), .NUM_PREDICATES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    bus.stall               = 1'b0;
    bus.flush               = 1'b0;
    bus.issue_valid         = 1'b0;
    bus.issue_dt            = DT_OTHER;
    bus.issue_di            = '0;
    bus.issue_up_true_mask  = '0;
    bus.issue_up_false_mask = '0;
    bus.wb_valid            = 1'b0;
    bus.wb_value            = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] dt, input logic [3:0] di,
                       input logic [7:0] t, input logic [7:0] f);
    bus.issue_valid         = 1'b1;
    bus.issue_dt            = dt;
    bus.issue_di            = di;
    bus.issue_up_true_mask  = t;
    bus.issue_up_false_mask = f;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.predicates !== 8'h00) begin errors++; $display("FAIL reset_predicates got %h expected 00", bus.predicates); end
    checks++; if (bus.pending_mask !== 8'h00) begin errors++; $display("FAIL reset_pending_mask got %h expected 00", bus.pending_mask); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b expected 0", bus.hazard); end
    checks++; if (bus.pending_count !== 2'd0) begin errors++; $display("FAIL reset_pending_count got %0d expected 0", bus.pending_count); end
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL reset_protocol_error got %b expected 0", bus.protocol_error); end
  endtask

  task automatic test_single_issue();
    issue(DT_PRED, 4'd3, 8'h00, 8'h00);
    cycle();
    idle();
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL single_hazard_c1 got %b expected 1", bus.hazard); end
    checks++; if (bus.pending_mask !== 8'h08) begin errors++; $display("FAIL single_mask_c1 got %h expected 08", bus.pending_mask); end
    cycle();
    checks++; if (bus.pending_mask !== 8'h08) begin errors++; $display("FAIL single_mask_c2 got %h expected 08", bus.pending_mask); end
    bus.wb_valid = 1'b1;
    bus.wb_value = 1'b1;
    cycle();
    idle();
    checks++; if (bus.predicates !== 8'h08) begin errors++; $display("FAIL single_retire_predicates got %h expected 08", bus.predicates); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL single_retire_hazard got %b expected 0", bus.hazard); end
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL single_protocol_error got %b expected 0", bus.protocol_error); end
  endtask

  task automatic test_stall();
    issue(DT_PRED, 4'd0, 8'h00, 8'h00);
    cycle();
    idle();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (bus.pending_count !== 2'd1) begin errors++; $display("FAIL stall_count_%0d got %0d expected 1", i, bus.pending_count); end
    end
    bus.stall = 1'b0;
    cycle();
    checks++; if (bus.pending_count !== 2'd1) begin errors++; $display("FAIL stall_count_unstalled1 got %0d expected 1", bus.pending_count); end
    checks++; if (bus.predicates !== 8'h08) begin errors++; $display("FAIL stall_no_early_retire got %h expected 08", bus.predicates); end
    bus.wb_valid = 1'b1;
    bus.wb_value = 1'b1;
    cycle();
    idle();
    checks++; if (bus.predicates !== 8'h09) begin errors++; $display("FAIL stall_retire_predicates got %h expected 09", bus.predicates); end
    checks++; if (bus.pending_count !== 2'd0) begin errors++; $display("FAIL stall_retire_count got %0d expected 0", bus.pending_count); end
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL stall_protocol_error got %b expected 0", bus.protocol_error); end
  endtask

  task automatic test_issue_wins();
    issue(DT_PRED, 4'd5, 8'hFF, 8'h00);
    cycle();
    idle();
    checks++; if (bus.predicates !== 8'hFF) begin errors++; $display("FAIL wins_setup_predicates got %h expected ff", bus.predicates); end
    cycle();
    issue(DT_OTHER, 4'd0, 8'h00, 8'h20);
    bus.wb_valid = 1'b1;
    bus.wb_value = 1'b1;
    cycle();
    idle();
    checks++; if (bus.predicates !== 8'hDF) begin errors++; $display("FAIL wins_predicates got %h expected df", bus.predicates); end
    cycle();
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL wins_protocol_error got %b expected 0", bus.protocol_error); end
  endtask

  task automatic test_back_to_back();
    issue(DT_PRED, 4'd1, 8'h00, 8'h00);
    cycle();
    checks++; if (bus.pending_mask !== 8'h02 || bus.pending_count !== 2'd1) begin errors++; $display("FAIL b2b_step1 got mask %h count %0d expected 02 1", bus.pending_mask, bus.pending_count); end
    issue(DT_PRED, 4'd6, 8'h00, 8'h00);
    cycle();
    idle();
    checks++; if (bus.pending_mask !== 8'h42 || bus.pending_count !== 2'd2) begin errors++; $display("FAIL b2b_step2 got mask %h count %0d expected 42 2", bus.pending_mask, bus.pending_count); end
    bus.wb_valid = 1'b1;
    bus.wb_value = 1'b0;
    cycle();
    checks++; if (bus.pending_mask !== 8'h40 || bus.pending_count !== 2'd1) begin errors++; $display("FAIL b2b_step3 got mask %h count %0d expected 40 1", bus.pending_mask, bus.pending_count); end
    checks++; if (bus.predicates !== 8'hDD) begin errors++; $display("FAIL b2b_retire1_predicates got %h expected dd", bus.predicates); end
    cycle();
    idle();
    checks++; if (bus.pending_mask !== 8'h00 || bus.pending_count !== 2'd0) begin errors++; $display("FAIL b2b_step4 got mask %h count %0d expected 00 0", bus.pending_mask, bus.pending_count); end
    checks++; if (bus.predicates !== 8'h9D) begin errors++; $display("FAIL b2b_retire2_predicates got %h expected 9d", bus.predicates); end
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL b2b_protocol_error got %b expected 0", bus.protocol_error); end
  endtask

  task automatic test_flush();
    issue(DT_PRED, 4'd2, 8'h00, 8'h00);
    cycle();
    issue(DT_PRED, 4'd4, 8'h00, 8'h00);
    cycle();
    issue(DT_PRED, 4'd7, 8'h80, 8'h00);
    bus.flush    = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_value = 1'b0;
    cycle();
    idle();
    checks++; if (bus.predicates !== 8'h99) begin errors++; $display("FAIL flush_predicates got %h expected 99", bus.predicates); end
    checks++; if (bus.pending_mask !== 8'h00) begin errors++; $display("FAIL flush_pending_mask got %h expected 00", bus.pending_mask); end
    checks++; if (bus.pending_count !== 2'd0) begin errors++; $display("FAIL flush_pending_count got %0d expected 0", bus.pending_count); end
    cycle();
    checks++; if (bus.pending_mask !== 8'h00) begin errors++; $display("FAIL flush_mask_later got %h expected 00", bus.pending_mask); end
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL flush_protocol_error got %b expected 0", bus.protocol_error); end
  endtask

  task automatic test_errors();
    do_reset();
    bus.wb_valid = 1'b1;
    bus.wb_value = 1'b1;
    cycle();
    idle();
    checks++; if (bus.protocol_error !== 1'b1) begin errors++; $display("FAIL err_spurious_wb got %b expected 1", bus.protocol_error); end
    checks++; if (bus.predicates !== 8'h00) begin errors++; $display("FAIL err_spurious_wb_predicates got %h expected 00", bus.predicates); end
    cycle();
    cycle();
    checks++; if (bus.protocol_error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", bus.protocol_error); end
    do_reset();
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL err_cleared_by_reset got %b expected 0", bus.protocol_error); end

    issue(DT_OTHER, 4'd0, 8'h03, 8'h01);
    cycle();
    idle();
    checks++; if (bus.protocol_error !== 1'b1) begin errors++; $display("FAIL err_overlap got %b expected 1", bus.protocol_error); end
    checks++; if (bus.predicates !== 8'h02) begin errors++; $display("FAIL err_overlap_false_wins got %h expected 02", bus.predicates); end
    do_reset();

    issue(DT_PRED, 4'd9, 8'h00, 8'h00);
    cycle();
    idle();
    checks++; if (bus.protocol_error !== 1'b1) begin errors++; $display("FAIL err_di_range got %b expected 1", bus.protocol_error); end
    checks++; if (bus.pending_mask !== 8'h00 || bus.hazard !== 1'b0) begin errors++; $display("FAIL err_di_range_mask got %h hazard %b expected 00 0", bus.pending_mask, bus.hazard); end
    cycle();
    bus.wb_valid = 1'b1;
    bus.wb_value = 1'b1;
    cycle();
    idle();
    checks++; if (bus.predicates !== 8'h00) begin errors++; $display("FAIL err_di_range_no_write got %h expected 00", bus.predicates); end
    do_reset();

    issue(DT_PRED, 4'd3, 8'h00, 8'h00);
    cycle();
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL err_waw_first got %b expected 0", bus.protocol_error); end
    issue(DT_PRED, 4'd3, 8'h00, 8'h00);
    cycle();
    idle();
    checks++; if (bus.protocol_error !== 1'b1) begin errors++; $display("FAIL err_waw got %b expected 1", bus.protocol_error); end
    checks++; if (bus.pending_count !== 2'd2) begin errors++; $display("FAIL err_waw_tracked got %0d expected 2", bus.pending_count); end
    do_reset();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_single_issue();
    test_stall();
    test_issue_wins();
    test_back_to_back();
    test_flush();
    test_errors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
